harvard_mem_arbiter: RTL
========================

Name: harvard_mem_arbiter

Overview:
- Shares one single-ported memory between the instruction and data ports of mips_cpu_harvard.
- Sits between the CPU and the unified memory model.
- Sequences each CPU step as: instruction fetch, decode settle, optional data access, then a one-cycle CPU clock-enable pulse.
- Holds fetched and read data in registers so the CPU sees stable inputs while it is stalled.

Parameters:
- WAIT_LIMIT, 16: consecutive mem_waitrequest-high cycles in one access before bus_error is raised.
- CNT_W, 32: width of step_count and stall_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global run enable; when low, no new step begins
- cpu_active  in  1  CPU active flag; low means the CPU has halted
- cpu_clk_enable  out  1  clock enable to the CPU; high for exactly one cycle per step
- cpu_instr_address  in  32  CPU fetch address
- cpu_instr_readdata  out  32  held instruction word
- cpu_data_address  in  32  CPU data address
- cpu_data_read  in  1  CPU data read request
- cpu_data_write  in  1  CPU data write request
- cpu_data_writedata  in  32  CPU store data
- cpu_data_readdata  out  32  held load data
- mem_address  out  32  shared memory address
- mem_read  out  1  shared memory read strobe
- mem_write  out  1  shared memory write strobe
- mem_writedata  out  32  shared memory write data
- mem_readdata  in  32  shared memory read data; valid when mem_read=1 and mem_waitrequest=0
- mem_waitrequest  in  1  memory stall
- bus_error  out  1  sticky timeout flag
- step_count  out  CNT_W  number of completed CPU steps
- stall_count  out  CNT_W  cycles in which cpu_clk_enable=0 and state is not HALT/IDLE

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: on a clk edge with reset=1, every register is cleared.

Reset values:
- cpu_clk_enable=0, mem_read=0, mem_write=0.
- mem_address=0, mem_writedata=0.
- cpu_instr_readdata=0, cpu_data_readdata=0.
- bus_error=0, step_count=0, stall_count=0, wait counter=0.
- state=IDLE.
- Reset asserted mid-access aborts the access immediately. mem_read and mem_write are low in the cycle after reset.

States:
- IDLE:
  - All strobes low.
  - Go to FETCH when enable=1 and cpu_active=1.
  - Go to HALT when cpu_active=0.
- FETCH:
  - mem_address=cpu_instr_address, mem_read=1.
  - On mem_waitrequest=0: capture mem_readdata into cpu_instr_readdata, then go to DECODE.
- DECODE:
  - One cycle with no memory strobe, so the CPU's combinational decode settles on the new instruction.
  - If cpu_data_write=1, go to DATA_WR.
  - Else if cpu_data_read=1, go to DATA_RD.
  - Else go to STEP.
  - If read and write are both high, write wins and the read is dropped.
- DATA_RD:
  - mem_address=cpu_data_address, mem_read=1.
  - On mem_waitrequest=0: capture mem_readdata into cpu_data_readdata, then go to STEP.
- DATA_WR:
  - mem_address=cpu_data_address, mem_write=1, mem_writedata=cpu_data_writedata.
  - On mem_waitrequest=0, go to STEP.
  - cpu_data_readdata is unchanged.
- STEP:
  - cpu_clk_enable=1 for this one cycle; step_count increments.
  - Next state is FETCH if enable=1 and cpu_active=1, IDLE if enable=0, HALT if cpu_active=0.
  - cpu_active is sampled in STEP, i.e. the value before the CPU's edge.
- HALT:
  - All strobes low. Stays in HALT until reset.

Outputs and counters:
- All outputs are registered. Memory strobes are asserted in the same cycle the state is entered.
- The wait counter clears on entry to each access state. It increments on each mem_waitrequest=1 cycle.
- When the wait counter reaches WAIT_LIMIT:
  - bus_error is set (sticky).
  - Strobes drop.
  - State goes to HALT.
- Minimum latency per step with zero wait states: 3 cycles without a data access (FETCH, DECODE, STEP), 4 cycles with one.
- step_count and stall_count wrap modulo 2^CNT_W.
- enable falling mid-access does not abort the access. The block completes through STEP, then goes to IDLE.

Test Plan:
- Zero-wait fetch-only: memory word 0 = 0x24010020, cpu_instr_address=0, no data request -> mem_read high for 1 cycle, cpu_instr_readdata=0x24010020, cpu_clk_enable pulses every 3rd cycle, step_count=1 after first pulse.
- Load with waitstates: data read at address 0x100 returning 0xDEADBEEF, mem_waitrequest high 2 cycles -> DATA_RD lasts 3 cycles, cpu_data_readdata=0xDEADBEEF at the STEP cycle, step period=6 cycles, stall_count advances by 5.
- Store: data write 0x12345678 to address 0x200 -> exactly one cycle with mem_write=1, mem_address=0x200, mem_writedata=0x12345678. cpu_data_readdata unchanged.
- Read and write both requested in DECODE -> only mem_write issued. No mem_read at the data address.
- Timeout: mem_waitrequest held high with WAIT_LIMIT=16 -> after 16 FETCH wait cycles bus_error=1, mem_read=0, state HALT, cpu_clk_enable stays 0 until reset.
- Reset mid-DATA_WR and halt: reset asserted during a stalled write -> next cycle mem_write=0 and all counters 0. Separately, cpu_active=0 during STEP -> HALT, no further mem_read.

Source files
------------

// File: rtl/harvard_mem_arbiter.sv
// harvard_mem_arbiter: time-multiplexes one single-ported memory between a Harvard CPU's
// instruction and data ports, stepping the CPU with a one-cycle clock-enable pulse.
module harvard_mem_arbiter #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cpu_active,
  output logic             cpu_clk_enable,
  input  logic [31:0]      cpu_instr_address,
  output logic [31:0]      cpu_instr_readdata,
  input  logic [31:0]      cpu_data_address,
  input  logic             cpu_data_read,
  input  logic             cpu_data_write,
  input  logic [31:0]      cpu_data_writedata,
  output logic [31:0]      cpu_data_readdata,
  output logic [31:0]      mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_writedata,
  input  logic [31:0]      mem_readdata,
  input  logic             mem_waitrequest,
  output logic             bus_error,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DATA_RD, DATA_WR, STEP, HALT} state_t;
  state_t state_q;
  logic [WW-1:0] wait_q;
  logic timeout;
  assign timeout = wait_q == WW'(WAIT_LIMIT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      wait_q             <= '0;
      cpu_clk_enable     <= 1'b0;
      cpu_instr_readdata <= '0;
      cpu_data_readdata  <= '0;
      mem_address        <= '0;
      mem_read           <= 1'b0;
      mem_write          <= 1'b0;
      mem_writedata      <= '0;
      bus_error          <= 1'b0;
      step_count         <= '0;
      stall_count        <= '0;
    end else begin
      cpu_clk_enable <= 1'b0;
      if (state_q != IDLE && state_q != HALT && !cpu_clk_enable)
        stall_count <= stall_count + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (!cpu_active) state_q <= HALT;
          else if (enable) begin
            state_q     <= FETCH;
            mem_read    <= 1'b1;
            mem_address <= cpu_instr_address;
            wait_q      <= '0;
          end
        end
        FETCH, DATA_RD, DATA_WR: begin
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state_q == FETCH) begin
              cpu_instr_readdata <= mem_readdata;
              state_q            <= DECODE;
            end else begin
              if (state_q == DATA_RD) cpu_data_readdata <= mem_readdata;
              state_q        <= STEP;
              cpu_clk_enable <= 1'b1;
            end
          end else if (timeout) begin
            wait_q    <= wait_q + WW'(1);
            bus_error <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state_q   <= HALT;
          end else wait_q <= wait_q + WW'(1);
        end
        DECODE: begin
          wait_q <= '0;
          // a simultaneous read request is dropped in favour of the write
          if (cpu_data_write) begin
            state_q       <= DATA_WR;
            mem_write     <= 1'b1;
            mem_address   <= cpu_data_address;
            mem_writedata <= cpu_data_writedata;
          end else if (cpu_data_read) begin
            state_q     <= DATA_RD;
            mem_read    <= 1'b1;
            mem_address <= cpu_data_address;
          end else begin
            state_q        <= STEP;
            cpu_clk_enable <= 1'b1;
          end
        end
        STEP: begin
          step_count <= step_count + CNT_W'(1);
          if (!cpu_active) state_q <= HALT;
          else if (enable) begin
            state_q     <= FETCH;
            mem_read    <= 1'b1;
            mem_address <= cpu_instr_address;
            wait_q      <= '0;
          end else state_q <= IDLE;
        end
        default: state_q <= HALT;
      endcase
    end
  end
endmodule
